// File: rtl/pace_output_stage_if.sv
// Pace request / lead-driver bundle between the pacemaker controller
// (master) and the output stage (slave).
interface pace_output_stage_if #(
    parameter int AMP_WIDTH = 8
);
    logic                 pace_req;
    logic [AMP_WIDTH-1:0] amp_code;
    logic                 lead_fault;
    logic                 clr_fault;
    logic                 stim_en;
    logic [AMP_WIDTH-1:0] dac_code;
    logic                 recharge_en;
    logic                 sense_blank;
    logic                 busy;
    logic                 done;
    logic                 fault_flag;
    logic [7:0]           drop_cnt;

    modport master (
        output pace_req, amp_code, lead_fault, clr_fault,
        input  stim_en, dac_code, recharge_en, sense_blank, busy, done,
               fault_flag, drop_cnt
    );

    modport slave (
        input  pace_req, amp_code, lead_fault, clr_fault,
        output stim_en, dac_code, recharge_en, sense_blank, busy, done,
               fault_flag, drop_cnt
    );
endinterface

// File: rtl/pace_output_stage.sv
// Biphasic lead-driver sequencer: stimulus, interphase gap, active recharge,
// post-pace blanking. All outputs are registered and decoded from the next
// state so they switch on the same edge as the state register.
//
//   state | meaning
//   IDLE  | waiting for an accepted pace request
//   STIM  | cathodic phase, stim_en=1, dac_code=latched amplitude
//   GAP   | interphase gap, all switches open
//   RECHG | active recharge, recharge_en=1
//   BLANK | post-recharge blanking, switches open
module pace_output_stage #(
    parameter int PW_CYCLES         = 4,
    parameter int INTERPHASE_CYCLES = 1,
    parameter int RECHARGE_CYCLES   = 8,
    parameter int BLANK_CYCLES      = 4,
    parameter int AMP_WIDTH         = 8
) (
    input  logic CLK,
    input  logic RSTn,
    pace_output_stage_if.slave bus
);
    typedef enum logic [2:0] {IDLE, STIM, GAP, RECHG, BLANK} state_t;

    localparam int MAX_A   = (PW_CYCLES > INTERPHASE_CYCLES) ? PW_CYCLES : INTERPHASE_CYCLES;
    localparam int MAX_B   = (RECHARGE_CYCLES > BLANK_CYCLES) ? RECHARGE_CYCLES : BLANK_CYCLES;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    // The counter holds "cycles remaining minus one", so CNT_MAX-1 is the top value.
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] PW_LOAD  = CW'(PW_CYCLES - 1);
    localparam logic [CW-1:0] IPH_LOAD = CW'((INTERPHASE_CYCLES > 0) ? INTERPHASE_CYCLES - 1 : 0);
    localparam logic [CW-1:0] RCH_LOAD = CW'(RECHARGE_CYCLES - 1);
    localparam logic [CW-1:0] BLK_LOAD = CW'(BLANK_CYCLES - 1);

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [AMP_WIDTH-1:0] amp_q, amp_nxt;
    logic                 flag_q, flag_nxt;
    logic [7:0]           drop_q, drop_nxt;

    logic                 stim_q, rech_q, blank_q, busy_q, done_q;
    logic [AMP_WIDTH-1:0] dac_q;

    // Next-state, counter reload, amplitude latch, fault flag and drop counter.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        amp_nxt   = amp_q;
        flag_nxt  = flag_q;
        drop_nxt  = drop_q;

        // Set wins over clear while the lead fault is still present.
        if (bus.lead_fault)
            flag_nxt = 1'b1;
        else if (bus.clr_fault)
            flag_nxt = 1'b0;

        if (bus.pace_req && (state != IDLE || flag_q) && drop_q != 8'hFF)
            drop_nxt = drop_q + 8'd1;

        case (state)
            IDLE: begin
                if (bus.pace_req && !flag_q && bus.amp_code != '0) begin
                    state_nxt = STIM;
                    cnt_nxt   = PW_LOAD;
                    amp_nxt   = bus.amp_code;
                end
            end
            STIM: begin
                if (bus.lead_fault) begin
                    state_nxt = RECHG;
                    cnt_nxt   = RCH_LOAD;
                end else if (cnt == '0) begin
                    if (INTERPHASE_CYCLES == 0) begin
                        state_nxt = RECHG;
                        cnt_nxt   = RCH_LOAD;
                    end else begin
                        state_nxt = GAP;
                        cnt_nxt   = IPH_LOAD;
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_nxt = RECHG;
                    cnt_nxt   = RCH_LOAD;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            RECHG: begin
                if (cnt == '0) begin
                    state_nxt = BLANK;
                    cnt_nxt   = BLK_LOAD;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            BLANK: begin
                if (cnt == '0)
                    state_nxt = IDLE;
                else
                    cnt_nxt = cnt - CW'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, counter and outputs registered from the next-state decode.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state   <= IDLE;
            cnt     <= '0;
            amp_q   <= '0;
            flag_q  <= 1'b0;
            drop_q  <= 8'd0;
            stim_q  <= 1'b0;
            dac_q   <= '0;
            rech_q  <= 1'b0;
            blank_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            amp_q   <= amp_nxt;
            flag_q  <= flag_nxt;
            drop_q  <= drop_nxt;
            stim_q  <= (state_nxt == STIM);
            dac_q   <= (state_nxt == STIM) ? amp_nxt : '0;
            rech_q  <= (state_nxt == RECHG);
            blank_q <= (state_nxt != IDLE);
            busy_q  <= (state_nxt != IDLE);
            done_q  <= (state == BLANK) && (state_nxt == IDLE);
        end
    end

    assign bus.stim_en     = stim_q;
    assign bus.dac_code    = dac_q;
    assign bus.recharge_en = rech_q;
    assign bus.sense_blank = blank_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.fault_flag  = flag_q;
    assign bus.drop_cnt    = drop_q;
endmodule
